mem_burst_reader: RTL and testbench

//  Read-side counterpart to the clocked array writer. On start, it issues sequential

---
 rtl/mem_burst_reader.sv | 117 +++++++++++
 tb/tb_mem_burst_reader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// Burst reader: streams len sequential words from a 1-cycle-latency memory onto a
// valid/ready port through a 2-entry buffer. Optional feature: MEM_BURST_READER_PARITY_EN adds out_par.
module mem_burst_reader #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
`ifdef MEM_BURST_READER_PARITY_EN
  output logic          out_par,
`endif
  output logic          out_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [AW:0]   ONE     = 1;
  localparam logic [AW-1:0] ADDR_HI = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW:0]   len_q, issued, issued_nx;
  logic [AW-1:0] addr;
  logic          infl, infl_last;

  logic [1:0][DW-1:0] buf_d;
  logic [1:0]         buf_l;
  logic               rptr, wptr;
  logic [1:0]         cnt, use_nx;
  logic               push, pop, last_issue;

  assign push       = infl;
  assign pop        = out_valid & out_ready;
  assign issued_nx  = issued + ONE;
  assign last_issue = (issued_nx == len_q);
  // A word leaving this cycle frees its slot, so the issue check counts it as gone;
  // this keeps 1 word/cycle under full ready without ever exceeding 2 entries.
  assign use_nx     = cnt + {1'b0, infl} - {1'b0, pop};
  assign mem_rd_en  = (state == S_READ) && (use_nx < 2'd2);
  assign mem_rd_addr = addr;

  assign busy      = (state == S_READ) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = buf_d[rptr];
  assign out_last  = buf_l[rptr] & out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      issued    <= '0;
      addr      <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl      <= mem_rd_en;
      infl_last <= mem_rd_en & last_issue;
      case (state)
        S_IDLE: if (start) begin
          len_q  <= len;
          addr   <= base;
          issued <= '0;
          state  <= (len == '0) ? S_DONE : S_READ;
        end
        S_READ: if (mem_rd_en) begin
          addr   <= (addr == ADDR_HI) ? '0 : addr + 1'b1;
          issued <= issued_nx;
          if (last_issue) state <= S_DRAIN;
        end
        S_DRAIN: if (pop && out_last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_d <= '0;
      buf_l <= '0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      cnt   <= '0;
    end else begin
      if (push) begin
        buf_d[wptr] <= mem_rd_data;
        buf_l[wptr] <= infl_last;
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef MEM_BURST_READER_PARITY_EN
  logic [1:0] buf_p;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       buf_p       <= '0;
    else if (push) buf_p[wptr] <= ^mem_rd_data;
  end
  assign out_par = buf_p[rptr];
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: fixed memory {A0,B1,C2,D3}, hand-computed beats.
module tb_mem_burst_reader;
  logic       clk = 0, rst = 1, start = 0, mem_rd_en, busy, done;
  logic [1:0] base = 0, mem_rd_addr;
  logic [2:0] len = 0;
  logic [7:0] mem_rd_data = 0, out_data;
  logic       out_valid, out_ready = 0, out_last;
`ifdef MEM_BURST_READER_PARITY_EN
  logic       out_par;
`endif
  logic [7:0] mem [4];

  int checks = 0, errors = 0;
  int nb, done_cyc, done_cnt, busy_cnt;
  logic [7:0] bd [8];
  logic       bl [8];
  int         bc [8];

  always #5 clk = ~clk;

  mem_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef MEM_BURST_READER_PARITY_EN
    .out_par(out_par),
`endif
    .out_last(out_last));

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always high; mode 1: ready high every third cycle
  task automatic run(input logic [1:0] b, input logic [2:0] l, input int mode, input logic second);
    logic [7:0] prev;
    logic       stall;
    nb = 0; done_cyc = -1; done_cnt = 0; busy_cnt = 0; stall = 0; prev = 0;
    @(posedge clk); #1;
    start = 1; base = b; len = l;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 40; c++) begin
      if (second && c == 1) begin start = 1; base = 2; len = 1; end
      else start = 0;
      out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      @(negedge clk);
      if (stall) chk("hold", out_data, prev);
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (busy) busy_cnt++;
      if (out_valid && out_ready && nb < 8) begin
        bd[nb] = out_data; bl[nb] = out_last; bc[nb] = c; nb++;
`ifdef MEM_BURST_READER_PARITY_EN
        chk("par", out_par, ^out_data);
`endif
      end
      stall = out_valid && !out_ready;
      prev  = out_data;
      @(posedge clk); #1;
      if (done_cyc >= 0 && c > done_cyc + 2) break;
    end
    start = 0;
  endtask

  task automatic chk4(input string tag, input logic [31:0] exp_data, input int last_idx);
    chk({tag, "_n"}, nb, 4);
    chk({tag, "_data"}, {bd[0], bd[1], bd[2], bd[3]}, exp_data);
    chk({tag, "_last"}, {bl[0], bl[1], bl[2], bl[3]}, 4'b1 << (3 - last_idx));
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    mem[0] = 8'hA0; mem[1] = 8'hB1; mem[2] = 8'hC2; mem[3] = 8'hD3;
    #12;
    chk("reset_outs", {busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last}, 0);
    @(negedge clk); rst = 0;

    // 1: straight burst, full ready
    run(2'd0, 3'd4, 0, 1'b0);
    chk4("t1", 32'hA0B1C2D3, 3);
    chk("t1_first_cyc", bc[0], 2);
    chk("t1_last_cyc", bc[3], 5);
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_busy_cnt", busy_cnt, 6);

    // 2: wrap-around
    run(2'd3, 3'd4, 0, 1'b0);
    chk4("t2", 32'hD3A0B1C2, 3);

    // 3: back-pressure
    run(2'd0, 3'd4, 1, 1'b0);
    chk4("t3", 32'hA0B1C2D3, 3);

    // 4: empty burst
    run(2'd1, 3'd0, 0, 1'b0);
    chk("t4_nb", nb, 0);
    chk("t4_busy", busy_cnt, 0);
    chk("t4_done_cyc", done_cyc, 0);
    chk("t4_done_cnt", done_cnt, 1);

    // 6: start while busy is ignored
    run(2'd0, 3'd4, 0, 1'b1);
    chk4("t6", 32'hA0B1C2D3, 3);

    // 5: reset after two words accepted
    @(posedge clk); #1;
    start = 1; base = 0; len = 4; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("t5_rst_outs", {busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last}, 0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("t5_no_done", done_cnt, 0);
    rst = 0;
    run(2'd1, 3'd1, 0, 1'b0);
    chk("t5_nb", nb, 1);
    chk("t5_word", {bl[0], bd[0]}, {1'b1, 8'hB1});
    chk("t5_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
